// File: rtl/jk_bank_pkg.sv
// +--------------------------------------------------------------------------+
// | jk_bank_pkg : shared FSM encoding and JK command encoding for the bank.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package jk_bank_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_CAPTURE  = 2'd1;
    localparam state_t ST_TRANSFER = 2'd2;

    // JK command encoding, indexed as {J, K}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    function automatic logic jk_next(input logic jb, input logic kb, input logic m);
        logic r;
        case ({jb, kb})
            JK_HOLD:   r = m;
            JK_RESET:  r = 1'b0;
            JK_SET:    r = 1'b1;
            JK_TOGGLE: r = ~m;
            default:   r = m;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jk_rr_pick.sv
// +--------------------------------------------------------------------------+
// | jk_rr_pick : combinational round-robin search, upward from last+1.       |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module jk_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [IDXW-1:0] winner_o,
    output logic            valid_o
);

    // Scan farthest offset first so the nearest requester overwrites the result.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int off = NREQ; off >= 1; off--) begin
            if (req_i[IDXW'((int'(last_i) + off) % NREQ)]) begin
                winner_o = IDXW'((int'(last_i) + off) % NREQ);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
// +--------------------------------------------------------------------------+
// | jk_bank_arbiter : round-robin arbiter sharing one JK master-slave bank.  |
// | Optional macro JK_BANK_LOCK_EN adds a per-requester lock input.          |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef JK_BANK_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*NBITS-1:0] j,
    input  logic [NREQ*NBITS-1:0] k,
    output logic [NREQ-1:0]       gnt,
    output logic [NBITS-1:0]      q,
    output logic                  busy,
    output logic                  done
);

    localparam int IDXW = $clog2(NREQ);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   winner_q, winner_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NBITS-1:0]  master_q, master_d;
    logic [NBITS-1:0]  slave_q, slave_d;
    logic              done_q, done_d;

    logic [IDXW-1:0]   rr_idx;
    logic              rr_valid;
    logic [IDXW-1:0]   sel_idx;
    logic              sel_valid;
    logic [NBITS-1:0]  j_sel, k_sel;

    jk_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (rr_idx),
        .valid_o  (rr_valid)
    );

`ifdef JK_BANK_LOCK_EN
    logic lock_q, lock_d;

    // A locked previous winner that is still requesting bypasses rotation.
    always_comb begin
        if (lock_q && req[last_q]) begin
            sel_idx   = last_q;
            sel_valid = 1'b1;
        end else begin
            sel_idx   = rr_idx;
            sel_valid = rr_valid;
        end
    end
`else
    assign sel_idx   = rr_idx;
    assign sel_valid = rr_valid;
`endif

    always_comb begin
        j_sel = '0;
        k_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner_q == IDXW'(i)) begin
                j_sel = j[i*NBITS +: NBITS];
                k_sel = k[i*NBITS +: NBITS];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        master_d = master_q;
        slave_d  = slave_q;
        done_d   = 1'b0;
`ifdef JK_BANK_LOCK_EN
        lock_d   = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (sel_valid) begin
                    winner_d = sel_idx;
                    gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                    state_d  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                for (int b = 0; b < NBITS; b++) begin
                    master_d[b] = jk_next(j_sel[b], k_sel[b], master_q[b]);
                end
`ifdef JK_BANK_LOCK_EN
                lock_d  = lock[winner_q];
`endif
                gnt_d   = '0;
                state_d = ST_TRANSFER;
            end
            ST_TRANSFER: begin
                slave_d = master_q;
                last_d  = winner_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            winner_q <= '0;
            last_q   <= IDXW'(NREQ - 1);
            gnt_q    <= '0;
            master_q <= '0;
            slave_q  <= '0;
            done_q   <= 1'b0;
`ifdef JK_BANK_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            master_q <= master_d;
            slave_q  <= slave_d;
            done_q   <= done_d;
`ifdef JK_BANK_LOCK_EN
            lock_q   <= lock_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign q    = slave_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_jk_bank_arbiter : self-checking bench for jk_bank_arbiter.            |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_jk_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int NBITS = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*NBITS-1:0] j, k;
    logic [NREQ-1:0]       gnt;
    logic [NBITS-1:0]      q;
    logic                  busy, done;
`ifdef JK_BANK_LOCK_EN
    logic [NREQ-1:0]       lock;
`endif

    always #5 clk = ~clk;

    jk_bank_arbiter #(
        .NREQ  (NREQ),
        .NBITS (NBITS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef JK_BANK_LOCK_EN
        .lock (lock),
`endif
        .req  (req),
        .j    (j),
        .k    (k),
        .gnt  (gnt),
        .q    (q),
        .busy (busy),
        .done (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] j0;
        logic [7:0] k0;
        logic [7:0] exp_q;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] q_sb[$];
    int         idx_sb[$];
    logic [7:0] prev_q;
    logic [3:0] exp_g;
    int         idx;

    initial begin
        // Requester-0 command chain; expected q follows the JK truth table from 0.
        vecs[0] = '{8'hF0, 8'h00, 8'hF0};
        vecs[1] = '{8'hFF, 8'hFF, 8'h0F};
        vecs[2] = '{8'hFF, 8'hFF, 8'hF0};
        vecs[3] = '{8'hAA, 8'h55, 8'hAA};
        vecs[4] = '{8'h00, 8'h00, 8'hAA};
        vecs[5] = '{8'h0F, 8'hF0, 8'h0F};
        vecs[6] = '{8'h3C, 8'h3C, 8'h33};
        vecs[7] = '{8'hC0, 8'h03, 8'hF0};

        rst = 1'b1;
        req = '0;
        j   = '0;
        k   = '0;
`ifdef JK_BANK_LOCK_EN
        lock = '0;
`endif
        repeat (2) tick();
        check("reset_gnt",  32'(gnt),  32'h0);
        check("reset_q",    32'(q),    32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            j[7:0] = vecs[i].j0;
            k[7:0] = vecs[i].k0;
            req    = 4'b0001;
            q_sb.push_back(vecs[i].exp_q);
            prev_q = q;
            tick();
            check("vec_gnt",  32'(gnt),  32'h1);
            check("vec_busy", 32'(busy), 32'h1);
            req = '0;
            tick();
            check("vec_gnt_drop",    32'(gnt),  32'h0);
            check("vec_q_stable",    32'(q),    32'(prev_q));
            check("vec_done_early",  32'(done), 32'h0);
            tick();
            check("vec_done", 32'(done), 32'h1);
            check("vec_idle", 32'(busy), 32'h0);
            check("vec_q",    32'(q),    32'(q_sb.pop_front()));
        end
        tick();
        check("done_pulse_width", 32'(done), 32'h0);

        // Continuous all-request load: rotation 0,1,2,3,0 at 3-cycle spacing.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        j   = '0;
        k   = '0;
        idx_sb = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 15) req = '0;
            if (c % 3 == 1) begin
                idx   = idx_sb.pop_front();
                exp_g = 4'b0001 << idx;
                check("rr_gnt", 32'(gnt), 32'(exp_g));
            end else begin
                check("rr_gnt_gap", 32'(gnt), 32'h0);
            end
        end
        tick();

        // Reset during TRANSFER aborts the command and restores the pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        j   = 32'h0000_FF00;
        k   = '0;
        req = 4'b0010;
        tick();
        check("abort_pre_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        tick();
        check("abort_pre_q", 32'(q), 32'hFF);
        j   = 32'h0000_0F00;
        k   = 32'h0000_0F00;
        req = 4'b0010;
        tick();
        check("abort_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        rst = 1'b1;
        #1;
        check("abort_q",    32'(q),    32'h0);
        check("abort_gnt0", 32'(gnt),  32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b0;
        check("abort_no_done", 32'(done), 32'h0);
        req = 4'b1010;
        tick();
        check("abort_regrant",  32'(gnt),  32'h2);
        check("abort_no_done2", 32'(done), 32'h0);
        req = '0;
        tick();
        tick();
        check("abort_regrant_q",    32'(q),    32'h0F);
        check("abort_regrant_done", 32'(done), 32'h1);

`ifdef JK_BANK_LOCK_EN
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        j    = '0;
        k    = '0;
        lock = 4'b0001;
        req  = 4'b0011;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 7) lock = '0;
            if (c == 10) req = '0;
            if (c % 3 == 1) begin
                exp_g = (c == 10) ? 4'b0010 : 4'b0001;
                check("lock_gnt", 32'(gnt), 32'(exp_g));
            end
        end
        tick();
`endif

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
